// File: rtl/ifetch_group_if.sv
// Instruction-memory line-read bus: one outstanding request, req held until gnt,
// one rvalid beat carrying the 128-bit line.
interface ifetch_group_if;
  logic         req;
  logic [31:0]  addr;
  logic         gnt;
  logic         rvalid;
  logic [127:0] rdata;

  modport master (output req, addr, input gnt, rvalid, rdata);
  modport slave  (input req, addr, output gnt, rvalid, rdata);
endinterface

// File: rtl/ifetch_group.sv
// ifetch_group: fetches aligned 4-word lines and feeds the instruction buffer lanes.
// Define IFETCH_PREFETCH_EN for a next-line register with one-ahead prefetch.
module ifetch_group_lane #(
  parameter int K     = 0,
  parameter int LANES = 4
) (
  input  logic                   en_i,
  input  logic [1:0]             ptr_i,
  input  logic [LANES-1:0][31:0] line_i,
  output logic [31:0]            data_o,
  output logic                   valid_o
);
  logic [2:0] pos;

  assign pos     = {1'b0, ptr_i} + 3'(K);
  assign valid_o = en_i && (pos < 3'(LANES));
  assign data_o  = valid_o ? line_i[pos[1:0]] : 32'h0;
endmodule

module ifetch_group #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          LANES    = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  input  logic [31:0] redirect_pc,
  input  logic [2:0]  in_count,
  output logic [31:0] Iin1,
  output logic [31:0] Iin2,
  output logic [31:0] Iin3,
  output logic [31:0] Iin4,
  output logic        Iin1Valid,
  output logic        Iin2Valid,
  output logic        Iin3Valid,
  output logic        Iin4Valid,
  output logic [31:0] fetch_pc,
  ifetch_group_if.master imem
);
  typedef enum logic [1:0] {FETCH, WAIT, DELIVER, DISCARD} state_e;

  state_e                 state_q, state_d;
  logic [31:0]            pc_q, pc_d;
  logic [1:0]             ptr_q, ptr_d;
  logic [LANES-1:0][31:0] line_q, line_d;
  logic                   started_q;
  logic                   req, busy, last;
  logic [31:0]            addr, line_nxt;
  logic [2:0]             cnt, rem, n;

  assign cnt      = (in_count > 3'd4) ? 3'd4 : in_count;
  assign rem      = 3'd4 - {1'b0, ptr_q};
  assign n        = (cnt < rem) ? cnt : rem;
  assign last     = (({1'b0, ptr_q} + n) == 3'd4);
  assign line_nxt = {pc_q[31:4] + 28'd1, 4'h0};

`ifdef IFETCH_PREFETCH_EN
  logic                   pf_q, pf_d, nvld_q, nvld_d, rv;
  logic [LANES-1:0][31:0] nline_q, nline_d;

  // pf_q is only ever set while delivering, so any rvalid then answers the prefetch
  assign rv   = imem.rvalid && pf_q;
  assign busy = (state_q == WAIT) || (state_q == DISCARD) || pf_q;
`else
  assign busy = (state_q == WAIT) || (state_q == DISCARD);
`endif

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ptr_d   = ptr_q;
    line_d  = line_q;
    req     = 1'b0;
    addr    = {pc_q[31:4], 4'h0};
`ifdef IFETCH_PREFETCH_EN
    pf_d    = pf_q;
    nvld_d  = nvld_q;
    nline_d = nline_q;
`endif
    case (state_q)
      FETCH: begin
        req = started_q;
        if (req && imem.gnt) state_d = WAIT;
      end
      WAIT: begin
        if (imem.rvalid) begin
          line_d  = imem.rdata;
          state_d = DELIVER;
`ifdef IFETCH_PREFETCH_EN
          req  = 1'b1;
          addr = line_nxt;
          pf_d = imem.gnt;
`endif
        end
      end
      DELIVER: begin
`ifdef IFETCH_PREFETCH_EN
        if (rv) pf_d = 1'b0;
        if (last) begin
          pc_d  = line_nxt;
          ptr_d = 2'd0;
          if (nvld_q || rv) begin
            // promote the next line in place and immediately ask for the one after
            line_d = nvld_q ? nline_q : imem.rdata;
            nvld_d = 1'b0;
            req    = 1'b1;
            addr   = {pc_q[31:4] + 28'd2, 4'h0};
            if (imem.gnt) pf_d = 1'b1;
          end else if (pf_q) begin
            state_d = WAIT;
            pf_d    = 1'b0;
          end else begin
            req     = 1'b1;
            addr    = line_nxt;
            state_d = imem.gnt ? WAIT : FETCH;
          end
        end else begin
          ptr_d = ptr_q + n[1:0];
          pc_d  = pc_q + {27'b0, n, 2'b00};
          if (rv) begin
            nline_d = imem.rdata;
            nvld_d  = 1'b1;
          end else if (!pf_q && !nvld_q) begin
            req  = 1'b1;
            addr = line_nxt;
            if (imem.gnt) pf_d = 1'b1;
          end
        end
`else
        if (last) begin
          pc_d    = line_nxt;
          ptr_d   = 2'd0;
          state_d = FETCH;
        end else begin
          ptr_d = ptr_q + n[1:0];
          pc_d  = pc_q + {27'b0, n, 2'b00};
        end
`endif
      end
      DISCARD: begin
        if (imem.rvalid) state_d = FETCH;
      end
      default: state_d = FETCH;
    endcase

    // Flush wins; a response landing in the flush cycle closes the transaction,
    // so only a still-unanswered (or just-granted) request needs DISCARD.
    if (flush) begin
      pc_d    = redirect_pc;
      ptr_d   = redirect_pc[3:2];
      line_d  = line_q;
      state_d = ((busy && !imem.rvalid) || (req && imem.gnt)) ? DISCARD : FETCH;
`ifdef IFETCH_PREFETCH_EN
      pf_d    = 1'b0;
      nvld_d  = 1'b0;
      nline_d = nline_q;
`endif
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= FETCH;
      pc_q      <= RESET_PC;
      ptr_q     <= RESET_PC[3:2];
      line_q    <= '0;
      started_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ptr_q     <= ptr_d;
      line_q    <= line_d;
      started_q <= 1'b1;
    end
  end

`ifdef IFETCH_PREFETCH_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pf_q    <= 1'b0;
      nvld_q  <= 1'b0;
      nline_q <= '0;
    end else begin
      pf_q    <= pf_d;
      nvld_q  <= nvld_d;
      nline_q <= nline_d;
    end
  end
`endif

  logic                   deliver;
  logic [LANES-1:0][31:0] lane_data;
  logic [LANES-1:0]       lane_vld;

  assign deliver = (state_q == DELIVER);

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    ifetch_group_lane #(.K(k), .LANES(LANES)) u_lane (
      .en_i   (deliver),
      .ptr_i  (ptr_q),
      .line_i (line_q),
      .data_o (lane_data[k]),
      .valid_o(lane_vld[k])
    );
  end

  assign Iin1      = lane_data[0];
  assign Iin2      = lane_data[1];
  assign Iin3      = lane_data[2];
  assign Iin4      = lane_data[3];
  assign Iin1Valid = lane_vld[0];
  assign Iin2Valid = lane_vld[1];
  assign Iin3Valid = lane_vld[2];
  assign Iin4Valid = lane_vld[3];
  assign fetch_pc  = pc_q;
  assign imem.req  = req;
  assign imem.addr = addr;
endmodule

// File: tb/tb_ifetch_group.sv
// Bench for ifetch_group (default build): directed test-plan cases with literal
// expectations, then randomized traffic against a flag-level fetch model.
module tb_ifetch_group;
  logic        clk = 1'b0;
  logic        reset;
  logic        flush;
  logic [31:0] redirect_pc;
  logic [2:0]  in_count;
  logic [31:0] Iin1, Iin2, Iin3, Iin4, fetch_pc;
  logic        Iin1Valid, Iin2Valid, Iin3Valid, Iin4Valid;

  ifetch_group_if imem_if ();

  ifetch_group dut (
    .clk(clk), .reset(reset), .flush(flush), .redirect_pc(redirect_pc),
    .in_count(in_count),
    .Iin1(Iin1), .Iin2(Iin2), .Iin3(Iin3), .Iin4(Iin4),
    .Iin1Valid(Iin1Valid), .Iin2Valid(Iin2Valid), .Iin3Valid(Iin3Valid), .Iin4Valid(Iin4Valid),
    .fetch_pc(fetch_pc), .imem(imem_if)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;

  // model: pc of oldest undelivered instruction plus where the fetch stands
  logic [31:0] m_pc;
  bit m_have, m_pend, m_drop, m_started, chk_en = 1'b0;
  // memory environment and inputs applied in the current cycle
  bit mem_busy;
  int mem_cnt, cur_lat;
  logic [31:0] mem_addr, cur_r, s_addr;
  logic [2:0] cur_c;
  bit cur_f, cur_g, cur_v, s_req;

  function automatic logic [31:0] word(input logic [31:0] a);
    return ({a[31:2], 2'b00} * 32'h9E37_79B1) ^ 32'h1357_9BDF;
  endfunction

  function automatic logic [127:0] line_of(input logic [31:0] a);
    logic [127:0] l;
    for (int k = 0; k < 4; k++) l[32*k +: 32] = word({a[31:4], 4'h0} + 32'(4*k));
    return l;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] vlds();
    return {28'h0, Iin4Valid, Iin3Valid, Iin2Valid, Iin1Valid};
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      int vc;
      bit exp_req;
      logic [3:0]  ev;
      logic [31:0] ed [4];
      vc      = m_have ? 4 - int'(m_pc[3:2]) : 0;
      exp_req = m_started && !m_have && !m_pend && !m_drop;
      for (int k = 0; k < 4; k++) begin
        ev[k] = (k < vc);
        ed[k] = ev[k] ? word(m_pc + 32'(4*k)) : 32'h0;
      end
      chk("valids", vlds(), {28'h0, ev});
      chk("lane1", Iin1, ed[0]);
      chk("lane2", Iin2, ed[1]);
      chk("lane3", Iin3, ed[2]);
      chk("lane4", Iin4, ed[3]);
      chk("fetch_pc", fetch_pc, m_pc);
      chk("req", {31'h0, imem_if.req}, {31'h0, exp_req});
      if (exp_req) chk("addr", imem_if.addr, {m_pc[31:4], 4'h0});
    end
  end

  task automatic drive(input bit f, input logic [31:0] r, input logic [2:0] c,
                       input bit g, input int lat, input bit spur);
    logic [127:0] rd;
    rd = {$urandom, $urandom, $urandom, $urandom};
    cur_f = f; cur_r = r; cur_c = c; cur_lat = lat; cur_v = 1'b0;
    if (mem_busy) begin
      mem_cnt--;
      if (mem_cnt == 0) begin
        cur_v = 1'b1;
        rd    = line_of(mem_addr);
      end
    end else begin
      cur_v = spur;
    end
    cur_g = g && !mem_busy;
    flush = f; redirect_pc = r; in_count = c;
    imem_if.gnt = cur_g; imem_if.rvalid = cur_v; imem_if.rdata = rd;
    @(negedge clk);
    s_req  = imem_if.req;
    s_addr = imem_if.addr;
  endtask

  task automatic tick();
    bit req_e;
    int rem, n;
    @(posedge clk);
    #1;
    req_e = m_started && !m_have && !m_pend && !m_drop;
    if (cur_f) begin
      m_drop = ((m_pend || m_drop) && !cur_v) || (req_e && cur_g);
      m_pc   = cur_r;
      m_have = 1'b0;
      m_pend = 1'b0;
    end else if (m_have) begin
      rem = 4 - int'(m_pc[3:2]);
      n   = (cur_c > 3'd4) ? 4 : int'(cur_c);
      if (n > rem) n = rem;
      if (n == rem) begin
        m_pc   = {m_pc[31:4] + 28'd1, 4'h0};
        m_have = 1'b0;
      end else begin
        m_pc = m_pc + 32'(4*n);
      end
    end else if (m_pend) begin
      if (cur_v) begin m_pend = 1'b0; m_have = 1'b1; end
    end else if (m_drop) begin
      if (cur_v) m_drop = 1'b0;
    end else if (req_e && cur_g) begin
      m_pend = 1'b1;
    end
    m_started = 1'b1;
    if (cur_v) mem_busy = 1'b0;
    if (s_req && cur_g) begin
      mem_busy = 1'b1;
      mem_addr = s_addr;
      mem_cnt  = cur_lat;
    end
  endtask

  initial begin
    reset = 1'b0; flush = 1'b0; redirect_pc = '0; in_count = '0;
    imem_if.gnt = 1'b0; imem_if.rvalid = 1'b0; imem_if.rdata = '0;
    m_pc = 32'h0; m_have = 0; m_pend = 0; m_drop = 0; m_started = 0;
    mem_busy = 0; mem_cnt = 0; mem_addr = '0; cur_lat = 1;
    cur_f = 0; cur_g = 0; cur_v = 0; cur_c = '0; cur_r = '0; s_req = 0; s_addr = '0;
    #12;
    chk("rst valids", vlds(), 32'h0);
    chk("rst lane1", Iin1, 32'h0);
    chk("rst req", {31'h0, imem_if.req}, 32'h0);
    chk("rst fetch_pc", fetch_pc, 32'h0);
    reset = 1'b1;
    tick();
    chk_en = 1'b1;

    drive(0, 0, 3'd4, 1, 1, 0);
    chk("first req", {31'h0, imem_if.req}, 32'h1);
    chk("first addr", imem_if.addr, 32'h0);
    tick();
    drive(0, 0, 3'd1, 0, 1, 0); tick();
    drive(0, 0, 3'd1, 0, 1, 0);
    chk("A..D valids", vlds(), 32'hF);
    chk("A..D pc", fetch_pc, 32'h0);
    chk("A..D lane4", Iin4, word(32'hC));
    tick();
    drive(0, 0, 3'd2, 0, 1, 0);
    chk("B..D valids", vlds(), 32'h7);
    chk("B..D pc", fetch_pc, 32'h4);
    chk("B..D lane1", Iin1, word(32'h4));
    tick();
    repeat (5) begin
      drive(0, 0, 3'd0, 1, 1, 0);
      chk("hold valids", vlds(), 32'h1);
      chk("hold pc", fetch_pc, 32'hC);
      chk("hold req", {31'h0, imem_if.req}, 32'h0);
      tick();
    end
    drive(0, 0, 3'd4, 0, 1, 0); tick();
    drive(0, 0, 3'd0, 1, 3, 0);
    chk("next addr", imem_if.addr, 32'h10);
    tick();
    drive(1, 32'h108, 3'd4, 0, 1, 0); tick();
    drive(0, 0, 3'd4, 1, 1, 0);
    chk("discard req", {31'h0, imem_if.req}, 32'h0);
    chk("discard pc", fetch_pc, 32'h108);
    tick();
    drive(0, 0, 3'd4, 0, 1, 0); tick();
    drive(0, 0, 3'd0, 1, 1, 0);
    chk("redirect addr", imem_if.addr, 32'h100);
    tick();
    drive(0, 0, 3'd0, 0, 1, 0); tick();
    drive(0, 0, 3'd0, 0, 1, 0);
    chk("unaligned valids", vlds(), 32'h3);
    chk("unaligned pc", fetch_pc, 32'h108);
    chk("unaligned lane1", Iin1, word(32'h108));
    tick();
    drive(0, 0, 3'd4, 0, 1, 0); tick();
    drive(0, 0, 3'd0, 1, 1, 0); tick();
    drive(1, 32'h2A4, 3'd4, 0, 1, 0); tick();
    drive(0, 0, 3'd0, 0, 1, 0);
    chk("flush+rv valids", vlds(), 32'h0);
    chk("flush+rv req", {31'h0, imem_if.req}, 32'h1);
    chk("flush+rv addr", imem_if.addr, 32'h2A0);
    tick();

    repeat (4000) begin
      drive(($urandom % 16) == 0, $urandom & 32'h0000_FFFC, 3'($urandom),
            ($urandom % 4) != 0, int'($urandom_range(1, 3)), ($urandom % 8) == 0);
      tick();
    end

    chk_en = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    chk("async rst valids", vlds(), 32'h0);
    chk("async rst req", {31'h0, imem_if.req}, 32'h0);
    chk("async rst pc", fetch_pc, 32'h0);
    chk("async rst lane1", Iin1, 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
